// File: rtl/instr_mem_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : instr_mem_pkg
//  Purpose  : Shared types and helpers for the instruction memory controller.
//             Holds the controller state encoding, default word/address
//             widths and the byte-address to word-index conversion.
//  Revision : 1.0 - initial release
// ============================================================================
package instr_mem_pkg;

    localparam int c_DATA_W = 32;
    localparam int c_ADDR_W = 32;

    // LOAD: boot image is being streamed in, fetch is blocked.
    // RUN : image is complete, fetch requests are serviced.
    typedef enum logic [0:0] {
        S_LOAD = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    // Word index of a byte offset (words are 4 bytes). Wide enough for any
    // supported address width so callers can range-check the full result.
    function automatic logic [63:0] word_index(input logic [63:0] byte_off);
        return byte_off >> 2;
    endfunction

endpackage
`default_nettype wire

// File: rtl/imem_ram.sv
`default_nettype none
// ============================================================================
//  Module   : imem_ram
//  Purpose  : Instruction word storage. One write port, one registered read
//             port, no reset, so the array maps onto block RAM.
//  Ports    : clk              - clock, rising edge
//             i_we/i_waddr/i_wdata - write strobe, word index, data
//             i_re/i_raddr     - read strobe, word index
//             o_rdata          - read data, valid the cycle after i_re; holds
//                                its value while i_re is low
//  Revision : 1.0 - initial release
// ============================================================================
module imem_ram #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 64,
    parameter int IDX_W  = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              i_we,
    input  logic [IDX_W-1:0]  i_waddr,
    input  logic [DATA_W-1:0] i_wdata,
    input  logic              i_re,
    input  logic [IDX_W-1:0]  i_raddr,
    output logic [DATA_W-1:0] o_rdata
);

    logic [DATA_W-1:0] r_mem [DEPTH];

    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
        if (i_re) begin
            o_rdata <= r_mem[i_raddr];
        end
    end

endmodule
`default_nettype wire

// File: rtl/instr_mem_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : instr_mem_ctrl
//  Purpose  : Synchronous instruction memory with a streaming boot-load port
//             and a fetch request/response handshake with back-pressure.
//  Ports    : clk, rst                  - clock, async active-high reset
//             ld_start/ld_valid/ld_data/ld_last - loader stream
//             ld_busy, ld_ovf           - loading status, sticky overflow
//             req_valid/req_addr/req_ready - fetch request (byte address)
//             rsp_valid/rsp_data/rsp_err/rsp_ready - fetch response
//  Revision : 1.0 - initial release
// ============================================================================
module instr_mem_ctrl
    import instr_mem_pkg::*;
#(
    parameter int                DATA_W    = c_DATA_W,
    parameter int                ADDR_W    = c_ADDR_W,
    parameter int                DEPTH     = 64,
    parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ld_start,
    input  logic              ld_valid,
    input  logic [DATA_W-1:0] ld_data,
    input  logic              ld_last,
    output logic              ld_busy,
    output logic              ld_ovf,
    input  logic              req_valid,
    input  logic [ADDR_W-1:0] req_addr,
    output logic              req_ready,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_data,
    output logic              rsp_err,
    input  logic              rsp_ready
);

    localparam int               c_IDX_W   = $clog2(DEPTH);
    localparam logic [c_IDX_W:0] c_CNT_ONE = 1;

    state_t             r_state, w_state_nxt;
    logic [c_IDX_W:0]   r_cnt, w_cnt_nxt;      // one extra bit marks "full"
    logic               r_start_pend, w_start_pend_nxt;
    logic               r_ovf, w_ovf_nxt;
    logic               r_rsp_valid, r_rsp_err, r_rsp_hit;

    logic               w_cnt_full, w_drainable, w_start_req;
    logic               w_ram_we, w_accept, w_addr_err;
    logic [ADDR_W-1:0]  w_off;
    logic [63:0]        w_word;
    logic [DATA_W-1:0]  w_ram_rdata;

    assign w_cnt_full  = r_cnt[c_IDX_W];
    assign w_drainable = !r_rsp_valid | rsp_ready;
    assign w_start_req = ld_start | r_start_pend;

    // Wrap-around subtraction folds addresses below BASE_ADDR into huge
    // offsets, so a single range compare catches both ends.
    assign w_off      = req_addr - BASE_ADDR;
    assign w_word     = word_index(64'(w_off));
    assign w_addr_err = (req_addr[1:0] != 2'b00) | (w_word >= 64'(DEPTH));
    assign w_accept   = req_valid & req_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= S_LOAD;
            r_cnt        <= '0;
            r_start_pend <= 1'b0;
            r_ovf        <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_cnt        <= w_cnt_nxt;
            r_start_pend <= w_start_pend_nxt;
            r_ovf        <= w_ovf_nxt;
        end
    end

    always_comb begin
        w_state_nxt      = r_state;
        w_cnt_nxt        = r_cnt;
        w_start_pend_nxt = r_start_pend;
        w_ovf_nxt        = r_ovf;
        w_ram_we         = 1'b0;
        ld_busy          = 1'b0;
        req_ready        = 1'b0;

        if (ld_start) begin
            w_ovf_nxt = 1'b0;
        end

        case (r_state)
            S_LOAD: begin
                ld_busy          = 1'b1;
                w_start_pend_nxt = 1'b0;
                // A restart wins over a word offered in the same cycle.
                if (ld_start) begin
                    w_cnt_nxt = '0;
                end else if (ld_valid) begin
                    if (w_cnt_full) begin
                        w_ovf_nxt = 1'b1;
                    end else begin
                        w_ram_we  = 1'b1;
                        w_cnt_nxt = r_cnt + c_CNT_ONE;
                    end
                    if (ld_last) begin
                        w_state_nxt = S_RUN;
                    end
                end
            end
            S_RUN: begin
                // Refuse new requests on the cycle a reload is taken so no
                // response is produced after entering LOAD.
                req_ready = w_drainable & !w_start_req;
                if (w_start_req & w_drainable) begin
                    w_state_nxt      = S_LOAD;
                    w_cnt_nxt        = '0;
                    w_start_pend_nxt = 1'b0;
                end else if (ld_start) begin
                    w_start_pend_nxt = 1'b1;
                end
            end
            default: begin
                w_state_nxt = S_LOAD;
            end
        endcase
    end

    // Output register. r_rsp_hit selects RAM data; faults and reset force
    // zero without needing a reset on the RAM read register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rsp_valid <= 1'b0;
            r_rsp_err   <= 1'b0;
            r_rsp_hit   <= 1'b0;
        end else if (w_accept) begin
            r_rsp_valid <= 1'b1;
            r_rsp_err   <= w_addr_err;
            r_rsp_hit   <= !w_addr_err;
        end else if (rsp_ready) begin
            r_rsp_valid <= 1'b0;
        end
    end

    imem_ram #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .IDX_W  (c_IDX_W)
    ) u_ram (
        .clk     (clk),
        .i_we    (w_ram_we),
        .i_waddr (r_cnt[c_IDX_W-1:0]),
        .i_wdata (ld_data),
        .i_re    (w_accept & !w_addr_err),
        .i_raddr (w_word[c_IDX_W-1:0]),
        .o_rdata (w_ram_rdata)
    );

    assign ld_ovf    = r_ovf;
    assign rsp_valid = r_rsp_valid;
    assign rsp_err   = r_rsp_err;
    assign rsp_data  = r_rsp_hit ? w_ram_rdata : '0;

endmodule
`default_nettype wire

// File: tb/tb_instr_mem_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_instr_mem_ctrl
//  Purpose  : Self-checking bench for instr_mem_ctrl. Expected responses are
//             queued at request acceptance and compared when drained.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_instr_mem_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        ld_start, ld_valid, ld_last;
    logic [31:0] ld_data;
    logic        ld_busy, ld_ovf;
    logic        req_valid, req_ready;
    logic [31:0] req_addr;
    logic        rsp_valid, rsp_err, rsp_ready;
    logic [31:0] rsp_data;
    // second instance, BASE_ADDR = 0x400, shares the loader stream
    logic        b_ld_busy, b_ld_ovf;
    logic        b_req_valid, b_req_ready;
    logic [31:0] b_req_addr;
    logic        b_rsp_valid, b_rsp_err, b_rsp_ready;
    logic [31:0] b_rsp_data;

    always #5 clk = ~clk;

    instr_mem_ctrl #(.DATA_W(32), .ADDR_W(32), .DEPTH(64), .BASE_ADDR(32'h0)) dut (
        .clk(clk), .rst(rst), .ld_start(ld_start), .ld_valid(ld_valid),
        .ld_data(ld_data), .ld_last(ld_last), .ld_busy(ld_busy), .ld_ovf(ld_ovf),
        .req_valid(req_valid), .req_addr(req_addr), .req_ready(req_ready),
        .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_err(rsp_err),
        .rsp_ready(rsp_ready)
    );

    instr_mem_ctrl #(.DATA_W(32), .ADDR_W(32), .DEPTH(64), .BASE_ADDR(32'h400)) dut_b (
        .clk(clk), .rst(rst), .ld_start(ld_start), .ld_valid(ld_valid),
        .ld_data(ld_data), .ld_last(ld_last), .ld_busy(b_ld_busy), .ld_ovf(b_ld_ovf),
        .req_valid(b_req_valid), .req_addr(b_req_addr), .req_ready(b_req_ready),
        .rsp_valid(b_rsp_valid), .rsp_data(b_rsp_data), .rsp_err(b_rsp_err),
        .rsp_ready(b_rsp_ready)
    );

    typedef struct packed {
        logic [31:0] data;
        logic        err;
    } rsp_t;

    rsp_t        sb[$];
    logic [31:0] tb_mem [64];
    int          mcnt;
    bit          movf;
    int          n_checks = 0;
    int          n_fail   = 0;
    bit          acc_prev = 1'b0;

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic rsp_t model_rsp(input logic [31:0] addr, input logic [31:0] base);
        logic [31:0] off;
        rsp_t        r;
        off    = addr - base;
        r.err  = (addr[1:0] != 2'b00) || (off >= 32'd256);
        r.data = r.err ? 32'd0 : tb_mem[off[7:2]];
        return r;
    endfunction

    // Scoreboard monitor for the BASE_ADDR=0 instance.
    always @(negedge clk) begin
        if (rst) begin
            acc_prev = 1'b0;
        end else begin
            if (acc_prev) check_val("latency", 64'(rsp_valid), 64'd1);
            if (rsp_valid) begin
                check_val("sb_nonempty", 64'(sb.size() > 0), 64'd1);
                if (sb.size() > 0) begin
                    check_val("rsp_data", 64'(rsp_data), 64'(sb[0].data));
                    check_val("rsp_err", 64'(rsp_err), 64'(sb[0].err));
                    if (rsp_ready) void'(sb.pop_front());
                end
            end
            acc_prev = req_valid && req_ready;
            if (acc_prev) sb.push_back(model_rsp(req_addr, 32'h0));
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic load_word(input logic [31:0] d, input bit last);
        ld_valid = 1'b1;
        ld_data  = d;
        ld_last  = last;
        if (mcnt < 64) begin
            tb_mem[mcnt] = d;
            mcnt++;
        end else begin
            movf = 1'b1;
        end
        #1;
        check_val("busy_in_load", 64'(ld_busy), 64'd1);
        check_val("no_fetch_in_load", 64'(req_ready), 64'd0);
        tick();
        ld_valid = 1'b0;
        ld_last  = 1'b0;
        if (last) begin
            check_val("busy_after_last", 64'(ld_busy), 64'd0);
            check_val("ovf_after_last", 64'(ld_ovf), 64'(movf));
        end
    endtask

    task automatic fetch(input logic [31:0] a);
        int k;
        k         = 0;
        req_valid = 1'b1;
        req_addr  = a;
        #1;
        while (!req_ready && k < 20) begin
            tick();
            #1;
            k++;
        end
        check_val("accept_in_time", 64'(k < 20), 64'd1);
        tick();
        req_valid = 1'b0;
    endtask

    task automatic fetch_b(input logic [31:0] a);
        int   k;
        rsp_t e;
        k           = 0;
        e           = model_rsp(a, 32'h400);
        b_req_valid = 1'b1;
        b_req_addr  = a;
        #1;
        while (!b_req_ready && k < 20) begin
            tick();
            #1;
            k++;
        end
        check_val("b_accept_in_time", 64'(k < 20), 64'd1);
        tick();
        b_req_valid = 1'b0;
        check_val("b_rsp_valid", 64'(b_rsp_valid), 64'd1);
        check_val("b_rsp_data", 64'(b_rsp_data), 64'(e.data));
        check_val("b_rsp_err", 64'(b_rsp_err), 64'(e.err));
        tick();
    endtask

    task automatic check_reset_outputs(input string tag);
        check_val({tag, "_busy"}, 64'(ld_busy), 64'd1);
        check_val({tag, "_ovf"}, 64'(ld_ovf), 64'd0);
        check_val({tag, "_req_ready"}, 64'(req_ready), 64'd0);
        check_val({tag, "_rsp_valid"}, 64'(rsp_valid), 64'd0);
        check_val({tag, "_rsp_data"}, 64'(rsp_data), 64'd0);
        check_val({tag, "_rsp_err"}, 64'(rsp_err), 64'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, got no finish expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;  ld_start = 1'b0; ld_valid = 1'b0; ld_last = 1'b0; ld_data = '0;
        req_valid = 1'b0; req_addr = '0; rsp_ready = 1'b1;
        b_req_valid = 1'b0; b_req_addr = '0; b_rsp_ready = 1'b1;
        mcnt = 0; movf = 1'b0;

        #12;
        check_reset_outputs("reset");
        @(posedge clk);
        #1 rst = 1'b0;

        // 1: load three words, fetch back-to-back
        load_word(32'hE3A00001, 1'b0);
        load_word(32'hE3A01002, 1'b0);
        load_word(32'hE0802001, 1'b1);
        fetch(32'h0);
        fetch(32'h4);
        fetch(32'h8);
        idle(3);
        check_val("sb_drained_1", 64'(sb.size()), 64'd0);

        // 2: back-pressure on the response to fetch 4
        fetch(32'h0);
        fetch(32'h4);
        rsp_ready = 1'b0;
        req_valid = 1'b1;
        req_addr  = 32'h8;
        for (int i = 0; i < 3; i++) begin
            #1;
            check_val("bp_req_ready", 64'(req_ready), 64'd0);
            check_val("bp_hold_data", 64'(rsp_data), 64'hE3A01002);
            tick();
        end
        rsp_ready = 1'b1;
        #1;
        check_val("bp_ready_on_drain", 64'(req_ready), 64'd1);
        tick();
        req_valid = 1'b0;
        check_val("bp_new_valid", 64'(rsp_valid), 64'd1);
        check_val("bp_new_data", 64'(rsp_data), 64'hE0802001);
        idle(2);

        // 3: faults
        fetch(32'h2);
        fetch(32'h100);
        fetch(32'hFFFF_FFFC);
        idle(2);
        fetch_b(32'h3FC);
        fetch_b(32'h404);
        fetch_b(32'h500);
        check_val("sb_drained_3", 64'(sb.size()), 64'd0);

        // 4: overflow with 66 words
        ld_start = 1'b1;
        mcnt = 0; movf = 1'b0;
        tick();
        ld_start = 1'b0;
        check_val("reload_busy", 64'(ld_busy), 64'd1);
        for (int i = 0; i < 66; i++) load_word(32'hA500_0000 + 32'(i), i == 65);
        check_val("b_ovf", 64'(b_ld_ovf), 64'd1);
        fetch(32'hFC);
        fetch(32'h0);
        fetch(32'h4);
        idle(3);

        // 5: ld_start while the response is stalled
        rsp_ready = 1'b0;
        fetch(32'h0);
        ld_start = 1'b1;
        movf = 1'b0;
        tick();
        ld_start = 1'b0;
        for (int i = 0; i < 2; i++) begin
            #1;
            check_val("pend_still_run", 64'(ld_busy), 64'd0);
            check_val("pend_rsp_held", 64'(rsp_valid), 64'd1);
            check_val("pend_ovf_clear", 64'(ld_ovf), 64'(movf));
            tick();
        end
        rsp_ready = 1'b1;
        tick();
        mcnt = 0;
        check_val("pend_now_load", 64'(ld_busy), 64'd1);
        check_val("pend_req_blocked", 64'(req_ready), 64'd0);
        check_val("pend_drained", 64'(rsp_valid), 64'd0);
        check_val("pend_ovf", 64'(ld_ovf), 64'd0);

        // 6: async reset part-way through a load, then reload
        load_word(32'hC0DE_0000, 1'b0);
        load_word(32'hC0DE_0001, 1'b0);
        #2 rst = 1'b1;
        #1;
        check_reset_outputs("async_rst");
        mcnt = 0;
        @(posedge clk);
        #1 rst = 1'b0;
        for (int i = 0; i < 5; i++) load_word(32'hD00D_0000 + 32'(i), i == 4);
        fetch(32'h0);
        fetch(32'h10);
        fetch(32'h14);
        idle(3);
        check_val("sb_drained_6", 64'(sb.size()), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/instr_mem_ctrl.md
Name: instr_mem_ctrl

Overview:
Parametrised synchronous instruction memory with a streaming boot-load port and a fetch request/response handshake with back-pressure.
- Sits between the command-line loader (which writes program words) and the processor fetch stage (which reads them).
- Supersedes the combinational a->rd instruction ROM: registered read, range and alignment checking, and run-time reloading.

Parameters:
DATA_W, 32, instruction word width in bits
ADDR_W, 32, fetch byte-address width
DEPTH, 64, number of words stored; power of 2, >= 2
BASE_ADDR, 0, byte address of word 0; word-aligned

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous active-high reset
ld_start  in  1  request (re)load; pulse
ld_valid  in  1  ld_data holds a word to store
ld_data  in  DATA_W  program word
ld_last  in  1  qualifies ld_valid: final word of image
ld_busy  out  1  block is in LOAD state
ld_ovf  out  1  sticky: word offered after DEPTH words stored
req_valid  in  1  fetch request
req_addr  in  ADDR_W  fetch byte address
req_ready  out  1  request accepted when req_valid & req_ready
rsp_valid  out  1  response held in output register
rsp_data  out  DATA_W  fetched word
rsp_err  out  1  response is a fault (range or alignment)
rsp_ready  in  1  consumer takes response when rsp_valid & rsp_ready

Behaviour:
- Reset (async, rst=1):
  - State goes to LOAD; load counter = 0.
  - rsp_valid=0, rsp_data=0, rsp_err=0, ld_ovf=0, ld_busy=1, req_ready=0.
  - Memory array is not reset; contents survive.
- States:
  - LOAD -> RUN on an accepted ld_valid&ld_last.
  - RUN -> LOAD on ld_start while the output register is empty, or emptied that same cycle (rsp_ready=1). Otherwise ld_start is held pending internally and taken on the first qualifying cycle.
  - ld_start while in LOAD restarts the counter at 0.
- LOAD:
  - Each ld_valid writes ld_data to mem[cnt]; cnt increments.
  - When cnt == DEPTH: further words are dropped, ld_ovf is set, and the counter does not wrap. ld_last still moves to RUN.
  - req_ready=0 throughout LOAD.
- RUN:
  - req_ready = !rsp_valid | rsp_ready (single-entry output register, full throughput).
  - Accepted request: one cycle later rsp_valid=1 and rsp_data/rsp_err are registered.
  - rsp_data/rsp_err hold stable while rsp_valid & !rsp_ready.
- Address decode:
  - off = req_addr - BASE_ADDR (ADDR_W wrap-around subtraction); idx = off >> 2.
  - Error if req_addr[1:0] != 0, or off >= DEPTH*4 (including req_addr < BASE_ADDR, via wrap).
  - On error: rsp_err=1, rsp_data=0. Otherwise rsp_err=0, rsp_data=mem[idx].
- Simultaneous events:
  - A response drains and a new request is accepted in the same cycle; rsp_valid stays 1 with new data.
  - ld_valid and a pending fetch never coexist, because fetch is blocked in LOAD.
  - ld_ovf clears only on rst or on ld_start.
- Reset mid-load: partial image remains in memory. Loader must restart from word 0; no fetch is serviced until a new ld_last.

Decomposition:
- Package instr_mem_pkg: state enum (S_LOAD, S_RUN), DATA_W/ADDR_W defaults, function for word index from byte address.
- One sub-module: imem_ram (single write port, single registered read port, no reset), holding the array so synthesis infers block RAM.

Test Plan:
1. Reset, then load 3 words 0xE3A00001, 0xE3A01002, 0xE0802001 (ld_last on 3rd) -> ld_busy falls the cycle after the 3rd word; fetch 0, 4, 8 back-to-back returns those words, each 1 cycle after acceptance, rsp_err=0.
2. Back-pressure: rsp_ready=0 for 3 cycles after fetch 4 -> rsp_data stays 0xE3A01002; req_ready=0 until rsp_ready=1; next request is accepted in the same cycle the response drains.
3. Fault cases:
   - Fetch 0x2 -> rsp_err=1, rsp_data=0.
   - Fetch 0x100 (DEPTH=64) -> rsp_err=1.
   - With BASE_ADDR=0x400, fetch 0x3FC -> rsp_err=1.
4. Overflow: DEPTH=64, stream 66 words, last one with ld_last -> ld_ovf=1, mem[63] = 64th word, mem[0] unchanged; fetch 0xFC returns the 64th word.
5. ld_start during RUN while rsp_valid=1 and rsp_ready=0 -> stays in RUN until drained, then ld_busy=1 and req_ready=0; ld_ovf cleared.
6. Assert rst after 2 of 5 load words -> all outputs return to reset values immediately (asynchronously); reload 5 words; fetch 0 returns the new word 0.
